// File: rtl/bellek_hakemi_pkg.sv
// bellek_hakemi_pkg
//   Shared types and constants for the memory-port arbiter: FSM state
//   encoding, requester ids, last-served encodings for the L1 round-robin
//   and the read data returned on a watchdog timeout.
package bellek_hakemi_pkg;

   typedef enum logic [1:0] {
      BOS    = 2'd0,   // idle, sampling requests
      MESGUL = 2'd1,   // transaction in flight towards memory
      HATA   = 2'd2    // watchdog fired, one-cycle error completion
   } durum_e;

   localparam logic [1:0] ISTEKCI_TIMER  = 2'd0;
   localparam logic [1:0] ISTEKCI_BUYRUK = 2'd1;
   localparam logic [1:0] ISTEKCI_VERI   = 2'd2;

   // Last L1 requester served; the other one wins the next L1 tie.
   localparam logic BUYRUK = 1'b0;
   localparam logic VERI   = 1'b1;

   localparam logic [31:0] HATA_RDATA = 32'h0;

endpackage

// File: rtl/bellek_hakemi_secici.sv
// hakem_secici
//   Combinational winner pick among timer, L1B and L1V.
//   Timer has absolute priority; a lone L1 requester wins; on an L1 tie
//   the requester not recorded in son_hizmet_i wins.
// Ports:
//   timer_valid_i, l1b_valid_i, l1v_valid_i : request valids
//   son_hizmet_i                            : last L1 served (BUYRUK/VERI)
//   secim_var_o                             : any request present
//   kazanan_o                               : winner id (ISTEKCI_*)
module hakem_secici
   import bellek_hakemi_pkg::*;
(
   input  logic       timer_valid_i,
   input  logic       l1b_valid_i,
   input  logic       l1v_valid_i,
   input  logic       son_hizmet_i,
   output logic       secim_var_o,
   output logic [1:0] kazanan_o
);

   always_comb begin
      secim_var_o = timer_valid_i | l1b_valid_i | l1v_valid_i;
      kazanan_o   = ISTEKCI_TIMER;
      if (timer_valid_i) begin
         kazanan_o = ISTEKCI_TIMER;
      end else if (l1b_valid_i && l1v_valid_i) begin
         kazanan_o = (son_hizmet_i == VERI) ? ISTEKCI_BUYRUK : ISTEKCI_VERI;
      end else if (l1b_valid_i) begin
         kazanan_o = ISTEKCI_BUYRUK;
      end else if (l1v_valid_i) begin
         kazanan_o = ISTEKCI_VERI;
      end
   end

endmodule

// File: rtl/bellek_hakemi.sv
// bellek_hakemi
//   Transaction-level arbiter in front of the main-memory port. A grant is
//   held for a whole transaction; address/strobes/data are registered at
//   grant time and frozen. A watchdog completes a transaction that memory
//   never acknowledges with zero read data and a hata_o pulse.
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   iomem_*                      : memory side (valid/ready/wstrb/addr/wdata/rdata)
//   timer_iomem_*                : timer requester (read-only, full address)
//   l1b_iomem_*                  : L1 instruction cache (read-only, word address)
//   l1v_iomem_*                  : L1 data cache (read/write, word address)
//   hata_o                       : one-cycle watchdog pulse
module bellek_hakemi
   import bellek_hakemi_pkg::*;
#(
   parameter int          ZAMAN_ASIMI = 255,
   parameter logic [7:0]  ADR_TABAN   = 8'h40
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        iomem_valid,
   input  logic        iomem_ready,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic [31:0] iomem_rdata,
   input  logic        timer_iomem_valid,
   input  logic [31:0] timer_iomem_addr,
   output logic        timer_iomem_ready,
   output logic [31:0] timer_iomem_rdata,
   input  logic        l1b_iomem_valid,
   output logic        l1b_iomem_ready,
   input  logic [16:0] l1b_iomem_addr,
   output logic [31:0] l1b_iomem_rdata,
   input  logic        l1v_iomem_valid,
   output logic        l1v_iomem_ready,
   input  logic [3:0]  l1v_iomem_wstrb,
   input  logic [16:0] l1v_iomem_addr,
   input  logic [31:0] l1v_iomem_wdata,
   output logic [31:0] l1v_iomem_rdata,
   output logic        hata_o
);

   localparam int SAYAC_W = $clog2(ZAMAN_ASIMI + 1);

   durum_e             durum_q, durum_d;
   logic [1:0]         istekci_q, istekci_d;
   logic [31:0]        adr_q, adr_d;
   logic [3:0]         wstrb_q, wstrb_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [SAYAC_W-1:0] sayac_q, sayac_d;
   logic               son_q, son_d;

   logic               secim_var;
   logic [1:0]         kazanan;
   logic [16:0]        l1_adr;
   logic               tamam;
   logic [31:0]        rdata_ortak;

   hakem_secici u_secici (
      .timer_valid_i (timer_iomem_valid),
      .l1b_valid_i   (l1b_iomem_valid),
      .l1v_valid_i   (l1v_iomem_valid),
      .son_hizmet_i  (son_q),
      .secim_var_o   (secim_var),
      .kazanan_o     (kazanan)
   );

   assign l1_adr = (kazanan == ISTEKCI_BUYRUK) ? l1b_iomem_addr : l1v_iomem_addr;

   always_comb begin
      durum_d   = durum_q;
      istekci_d = istekci_q;
      adr_d     = adr_q;
      wstrb_d   = wstrb_q;
      wdata_d   = wdata_q;
      sayac_d   = sayac_q;
      son_d     = son_q;
      case (durum_q)
         BOS: begin
            if (secim_var) begin
               istekci_d = kazanan;
               adr_d     = (kazanan == ISTEKCI_TIMER) ? timer_iomem_addr
                                                      : {ADR_TABAN, 5'b0, l1_adr, 2'b0};
               wstrb_d   = (kazanan == ISTEKCI_VERI) ? l1v_iomem_wstrb : 4'h0;
               wdata_d   = l1v_iomem_wdata;
               sayac_d   = '0;
               durum_d   = MESGUL;
            end
         end
         MESGUL: begin
            // Ready on the limit cycle still completes normally.
            if (iomem_ready) begin
               durum_d = BOS;
               if (istekci_q != ISTEKCI_TIMER)
                  son_d = (istekci_q == ISTEKCI_VERI) ? VERI : BUYRUK;
            end else if (sayac_q == SAYAC_W'(ZAMAN_ASIMI - 1)) begin
               durum_d = HATA;
            end else begin
               sayac_d = sayac_q + SAYAC_W'(1);
            end
         end
         HATA: begin
            durum_d = BOS;
            if (istekci_q != ISTEKCI_TIMER)
               son_d = (istekci_q == ISTEKCI_VERI) ? VERI : BUYRUK;
         end
         default: durum_d = BOS;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         durum_q   <= BOS;
         istekci_q <= ISTEKCI_TIMER;
         adr_q     <= '0;
         wstrb_q   <= '0;
         wdata_q   <= '0;
         sayac_q   <= '0;
         son_q     <= VERI;
      end else begin
         durum_q   <= durum_d;
         istekci_q <= istekci_d;
         adr_q     <= adr_d;
         wstrb_q   <= wstrb_d;
         wdata_q   <= wdata_d;
         sayac_q   <= sayac_d;
         son_q     <= son_d;
      end
   end

   // Outputs decode straight from the state register so an async reset
   // drops valid and every ready without waiting for an edge.
   assign iomem_valid = (durum_q == MESGUL);
   assign iomem_addr  = adr_q;
   assign iomem_wstrb = wstrb_q;
   assign iomem_wdata = wdata_q;
   assign hata_o      = (durum_q == HATA);

   assign tamam       = ((durum_q == MESGUL) && iomem_ready) || (durum_q == HATA);
   assign rdata_ortak = (durum_q == HATA) ? HATA_RDATA : iomem_rdata;

   assign timer_iomem_ready = tamam && (istekci_q == ISTEKCI_TIMER);
   assign l1b_iomem_ready   = tamam && (istekci_q == ISTEKCI_BUYRUK);
   assign l1v_iomem_ready   = tamam && (istekci_q == ISTEKCI_VERI);

   assign timer_iomem_rdata = rdata_ortak;
   assign l1b_iomem_rdata   = rdata_ortak;
   assign l1v_iomem_rdata   = rdata_ortak;

endmodule

// File: doc/bellek_hakemi.md
# bellek_hakemi

Transaction-level arbiter between the main-memory port (`iomem_*`) and its three requesters: timer, L1 instruction cache (L1B) and L1 data cache (L1V). The grant is held for a whole transaction, and request fields are registered towards memory. The timer has priority at transaction boundaries. L1B and L1V alternate round-robin. A watchdog ends any transaction that memory never acknowledges. The block sits between the cache/timer layer and the memory subsystem.

## Interface
Parameters:
- `ZAMAN_ASIMI`, default 255: cycles of unanswered `iomem_valid` before the watchdog ends the transaction. Legal range is 2..65535.
- `ADR_TABAN`, default 8'h40: top address byte applied to L1 addresses.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `iomem_valid`  out  1  memory request valid.
- `iomem_ready`  in  1  memory acknowledge.
- `iomem_wstrb`  out  4  write strobes; 0 means read.
- `iomem_addr`  out  32  byte address.
- `iomem_wdata`  out  32  write data.
- `iomem_rdata`  in  32  read data.
- `timer_iomem_valid`  in  1  timer read request.
- `timer_iomem_addr`  in  32  timer address, passed through unchanged.
- `timer_iomem_ready`  out  1  timer completion pulse.
- `timer_iomem_rdata`  out  32  timer read data.
- `l1b_iomem_valid` / `l1b_iomem_ready`  in / out  1  L1B request and completion.
- `l1b_iomem_addr`  in  17  word address, bits [18:2].
- `l1b_iomem_rdata`  out  32  L1B read data.
- `l1v_iomem_valid` / `l1v_iomem_ready`  in / out  1  L1V request and completion.
- `l1v_iomem_wstrb`  in  4  L1V write strobes.
- `l1v_iomem_addr`  in  17  word address, bits [18:2].
- `l1v_iomem_wdata`  in  32  L1V write data.
- `l1v_iomem_rdata`  out  32  L1V read data.
- `hata_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
FSM states: BOS (idle), MESGUL (busy), HATA (error).

**BOS**
- Sample the valids and pick a winner:
  - The timer always wins if its valid is high.
  - Otherwise a lone L1 requester wins.
  - If both L1B and L1V are valid, the one not recorded in `son_hizmet` wins.
- On a pick, register:
  - the requester id;
  - `iomem_addr`: `timer_iomem_addr` for the timer, or {ADR_TABAN, 5'b0, addr[18:2], 2'b0} for L1;
  - `iomem_wstrb`: L1V strobes for L1V, 0 for L1B and timer;
  - `iomem_wdata`: `l1v_iomem_wdata`.
- Set `iomem_valid` and go to MESGUL. The watchdog counter clears to 0.

**MESGUL**
- `iomem_valid`=1. Address, strobes and data stay frozen at the registered values.
- `iomem_ready`=1:
  - The granted requester's `*_ready` = `iomem_ready` combinationally, in the same cycle.
  - Its `*_rdata` = `iomem_rdata`.
  - `son_hizmet` is updated if the requester was L1.
  - Next state BOS; `iomem_valid` drops on the next edge.
- `iomem_ready`=0: the counter increments. At counter == ZAMAN_ASIMI-1 with no ready, go to HATA.
- Ready in the same cycle as the watchdog limit: ready wins and the transaction completes normally.

**HATA** (one cycle)
- `iomem_valid`=0.
- The granted requester's `*_ready`=1 with `*_rdata`=32'h0.
- `hata_o`=1.
- Next state BOS. `son_hizmet` is updated as for a normal completion.

**General rules**
- Non-granted requesters always see ready=0.
- All `*_rdata` outputs show `iomem_rdata` except during HATA, when they show 0.
- A requester dropping valid mid-transaction is ignored; the transaction runs to completion or timeout.
- Requests never preempt an active transaction. A timer request arriving in MESGUL waits for BOS.

**Reset values:**
- state BOS;
- `iomem_valid`, `iomem_wstrb`, `iomem_addr`, `iomem_wdata`, all `*_ready`, `hata_o` all 0;
- counter 0;
- `son_hizmet`=VERI, so the first tie goes to L1B.

Asserting `rst_i` mid-transaction clears everything immediately: `iomem_valid` falls without an edge and no ready is issued.

## Timing
- Request latency: a valid sampled in BOS at edge N gives `iomem_valid`=1 from N+1.
- Completion: the ready cycle R gives the requester's ready in cycle R.
- The earliest next grant is sampled in BOS at R+1, so `iomem_valid` is low for at least one cycle between transactions.
- Minimum transaction: 3 cycles from the request edge to BOS.
- Watchdog: `iomem_valid` is high for exactly ZAMAN_ASIMI cycles, then there is one HATA cycle.
- Counter width: $clog2(ZAMAN_ASIMI+1) bits, with no wrap-around possible.

## Structure
- Package `bellek_hakemi_pkg`:
  - state enum (BOS, MESGUL, HATA);
  - requester id constants (ISTEKCI_TIMER, ISTEKCI_BUYRUK, ISTEKCI_VERI);
  - the `VERI`/`BUYRUK` encodings for `son_hizmet`;
  - HATA_RDATA = 32'h0.
- Optional sub-module `hakem_secici`: combinational priority + round-robin pick from three valids and `son_hizmet`, returning the winner id. The FSM, registers and watchdog stay in the top module.

## Test plan
- L1B read of addr 17'h00010 with ready after 2 cycles → `iomem_addr`=32'h4000_0040, wstrb=0. `l1b_iomem_ready` is high for 1 cycle carrying rdata 32'hCAFE_0001; `l1v_iomem_ready` stays 0.
- L1B and L1V valid together from reset, both held → L1B is granted first, then L1V (wstrb 4'hF, wdata 32'h1234_5678), then L1B. Grants alternate strictly.
- Timer (addr 32'h3000_0000) raised while an L1V transaction is in MESGUL → the L1V transaction finishes uninterrupted. The timer is granted next, ahead of a pending L1B, with wstrb=0.
- ZAMAN_ASIMI=4 and `iomem_ready` held 0 → `iomem_valid` is high for 4 cycles. Then one cycle of `l1v_iomem_ready`=1, rdata=0 and `hata_o`=1, then BOS.
- ZAMAN_ASIMI=4 with ready arriving in the 4th valid cycle → normal completion, `hata_o` stays 0.
- `rst_i` asserted mid-MESGUL between clock edges → `iomem_valid` and all readys are 0 immediately. After release, the first L1B/L1V tie goes to L1B.
